// File: rtl/pipeline_readreg_skid.sv
// pipeline_readreg_skid: decode -> execute pipeline register with a
// valid/ready handshake and a two-deep skid (main + skid) so that
// backpressure never drops an instruction. A synchronous flush discards
// everything for branch redirect. When no entry is held, the control-type
// outputs read as zero.
// Optional build macro: PIPELINE_READREG_HAZARD_EN enables the load-use
// interlock (hazard_stall). When it is undefined, hazard_stall is tied low
// and no comparators are built.
module pipeline_readreg_skid #(
    parameter int CTRL_W        = 22,
    parameter int RNUM_W        = 3,
    parameter int IMM_W         = 16,
    parameter int TYPE_W        = 6,
    parameter int COND_W        = 3,
    parameter int LOAD_BIT      = 8,
    parameter int LINK_TYPE_BIT = 2,
    parameter int LINK_IMM_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control_in,
    input  logic [RNUM_W-1:0] num_Rm_in,
    input  logic [RNUM_W-1:0] num_Rn_in,
    input  logic [RNUM_W-1:0] num_Rd_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [2:0]        used_RmRnRd_in,
    input  logic [TYPE_W-1:0] inst_type_in,
    input  logic [IMM_W-1:0]  delayed_B_in,
    input  logic [COND_W-1:0] delayed_cond_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] control_out,
    output logic [RNUM_W-1:0] num_Rm_out,
    output logic [RNUM_W-1:0] num_Rn_out,
    output logic [RNUM_W-1:0] num_Rd_out,
    output logic [IMM_W-1:0]  imm_out,
    output logic [2:0]        used_RmRnRd_out,
    output logic [TYPE_W-1:0] inst_type_out,
    output logic [IMM_W-1:0]  delayed_B_out,
    output logic [COND_W-1:0] delayed_cond_out,
    output logic              loads,
    output logic              hazard_stall
);

    localparam int PAY_W = CTRL_W + 3 * RNUM_W + IMM_W + 3 + TYPE_W + IMM_W + COND_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [PAY_W-1:0]  main_r;
    logic [PAY_W-1:0]  skid_r;
    logic [PAY_W-1:0]  in_pay_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              main_from_in_s;
    logic              main_from_skid_s;
    logic              skid_from_in_s;

    // Head-entry fields unpacked from the main register
    logic [CTRL_W-1:0] h_ctrl_s;
    logic [RNUM_W-1:0] h_rm_s;
    logic [RNUM_W-1:0] h_rn_s;
    logic [RNUM_W-1:0] h_rd_s;
    logic [IMM_W-1:0]  h_imm_s;
    logic [2:0]        h_used_s;
    logic [TYPE_W-1:0] h_type_s;
    logic [IMM_W-1:0]  h_db_s;
    logic [COND_W-1:0] h_cond_s;

    assign in_pay_s = {control_in, num_Rm_in, num_Rn_in, num_Rd_in, imm_in,
                       used_RmRnRd_in, inst_type_in, delayed_B_in, delayed_cond_in};

    assign {h_ctrl_s, h_rm_s, h_rn_s, h_rd_s, h_imm_s,
            h_used_s, h_type_s, h_db_s, h_cond_s} = main_r;

    // Handshake qualifiers; in_ready depends only on state, flush and the
    // interlock, never on out_ready
    assign out_valid  = (state_r != ST_EMPTY);
    assign in_ready   = (state_r != ST_FULL) & ~flush & ~hazard_stall;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

`ifdef PIPELINE_READREG_HAZARD_EN
    // Load-use interlock against the head entry only
    assign hazard_stall = in_valid & loads &
                          ((used_RmRnRd_in[0] & (num_Rm_in == h_rd_s)) |
                           (used_RmRnRd_in[1] & (num_Rn_in == h_rd_s)));
`else
    assign hazard_stall = 1'b0;
`endif

    // Next-state and storage-load selection for the main/skid pair
    always_comb begin
        state_nxt_s      = state_r;
        main_from_in_s   = 1'b0;
        main_from_skid_s = 1'b0;
        skid_from_in_s   = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_from_in_s = 1'b1;
                        state_nxt_s    = ST_ONE;
                    end else begin
                        state_nxt_s    = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_from_in_s = 1'b1;
                        state_nxt_s    = ST_ONE;
                    end else if (in_fire_s) begin
                        skid_from_in_s = 1'b1;
                        state_nxt_s    = ST_FULL;
                    end else if (out_fire_s) begin
                        state_nxt_s    = ST_EMPTY;
                    end else begin
                        state_nxt_s    = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the input is never captured
                    if (out_fire_s) begin
                        main_from_skid_s = 1'b1;
                        state_nxt_s      = ST_ONE;
                    end else begin
                        state_nxt_s      = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register; reset outranks flush and any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Payload registers; not reset because the state marks them invalid
    always_ff @(posedge clk) begin
        if (main_from_in_s) begin
            main_r <= in_pay_s;
        end else if (main_from_skid_s) begin
            main_r <= skid_r;
        end
        if (skid_from_in_s) begin
            skid_r <= in_pay_s;
        end
    end

    // Head outputs; control-type fields are gated to zero on a bubble
    always_comb begin
        control_out      = out_valid ? h_ctrl_s : {CTRL_W{1'b0}};
        used_RmRnRd_out  = out_valid ? h_used_s : 3'b000;
        inst_type_out    = out_valid ? h_type_s : {TYPE_W{1'b0}};
        delayed_cond_out = out_valid ? h_cond_s : {COND_W{1'b0}};
        num_Rm_out       = h_rm_s;
        num_Rn_out       = h_rn_s;
        num_Rd_out       = h_rd_s;
        delayed_B_out    = h_db_s;
        loads            = out_valid & h_ctrl_s[LOAD_BIT];
        // BL/BLX carry the low bits of the delayed target as their immediate
        if (inst_type_out[LINK_TYPE_BIT]) begin
            imm_out = {{(IMM_W-LINK_IMM_W){1'b0}}, h_db_s[LINK_IMM_W-1:0]};
        end else begin
            imm_out = h_imm_s;
        end
    end

endmodule

// File: tb/tb_pipeline_readreg_skid.sv
// Testbench for pipeline_readreg_skid: directed scenarios followed by random
// traffic, all checked against a queue-based model of a two-entry FIFO.
module tb_pipeline_readreg_skid;

    typedef struct {
        logic [21:0] ctrl;
        logic [2:0]  rm;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic [2:0]  used;
        logic [5:0]  typ;
        logic [15:0] db;
        logic [2:0]  cond;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] control_in;
    logic [2:0]  num_Rm_in;
    logic [2:0]  num_Rn_in;
    logic [2:0]  num_Rd_in;
    logic [15:0] imm_in;
    logic [2:0]  used_RmRnRd_in;
    logic [5:0]  inst_type_in;
    logic [15:0] delayed_B_in;
    logic [2:0]  delayed_cond_in;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] control_out;
    logic [2:0]  num_Rm_out;
    logic [2:0]  num_Rn_out;
    logic [2:0]  num_Rd_out;
    logic [15:0] imm_out;
    logic [2:0]  used_RmRnRd_out;
    logic [5:0]  inst_type_out;
    logic [15:0] delayed_B_out;
    logic [2:0]  delayed_cond_out;
    logic        loads;
    logic        hazard_stall;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];

    pipeline_readreg_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .control_in(control_in), .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in),
        .num_Rd_in(num_Rd_in), .imm_in(imm_in), .used_RmRnRd_in(used_RmRnRd_in),
        .inst_type_in(inst_type_in), .delayed_B_in(delayed_B_in),
        .delayed_cond_in(delayed_cond_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .control_out(control_out), .num_Rm_out(num_Rm_out), .num_Rn_out(num_Rn_out),
        .num_Rd_out(num_Rd_out), .imm_out(imm_out), .used_RmRnRd_out(used_RmRnRd_out),
        .inst_type_out(inst_type_out), .delayed_B_out(delayed_B_out),
        .delayed_cond_out(delayed_cond_out), .loads(loads), .hazard_stall(hazard_stall)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [21:0] c, input logic [2:0] rm, input logic [2:0] rd,
                                input logic [2:0] used, input logic [5:0] typ,
                                input logic [15:0] imm, input logic [15:0] db);
        ent_t e;
        e.ctrl = c; e.rm = rm; e.rn = 3'd5; e.rd = rd; e.imm = imm;
        e.used = used; e.typ = typ; e.db = db; e.cond = 3'd6;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.ctrl = 22'($urandom);
        e.rm   = 3'($urandom);
        e.rn   = 3'($urandom);
        e.rd   = 3'($urandom);
        e.imm  = 16'($urandom);
        e.used = 3'($urandom);
        e.typ  = 6'($urandom);
        e.db   = 16'($urandom);
        e.cond = 3'($urandom);
        return e;
    endfunction

    // One clock cycle: drive, check against the FIFO model, advance the model
    task automatic step(input logic r, input logic f, input logic iv, input logic ordy, input ent_t e);
        logic exp_valid;
        logic exp_haz;
        logic exp_rdy;
        logic in_fire;
        logic out_fire;
        ent_t h;
        rst = r; flush = f; in_valid = iv; out_ready = ordy;
        control_in = e.ctrl; num_Rm_in = e.rm; num_Rn_in = e.rn; num_Rd_in = e.rd;
        imm_in = e.imm; used_RmRnRd_in = e.used; inst_type_in = e.typ;
        delayed_B_in = e.db; delayed_cond_in = e.cond;
        #3;
        exp_valid = (q.size() > 0);
        exp_haz   = 1'b0;
`ifdef PIPELINE_READREG_HAZARD_EN
        if (exp_valid && iv && q[0].ctrl[8])
            exp_haz = (e.used[0] && e.rm == q[0].rd) || (e.used[1] && e.rn == q[0].rd);
`endif
        exp_rdy = (q.size() < 2) && !f && !exp_haz;
        check_val("out_valid", 32'(out_valid), 32'(exp_valid));
        check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_val("hazard_stall", 32'(hazard_stall), 32'(exp_haz));
        if (exp_valid) begin
            h = q[0];
            check_val("control", 32'(control_out), 32'(h.ctrl));
            check_val("loads", 32'(loads), 32'(h.ctrl[8]));
            check_val("regs", 32'({num_Rm_out, num_Rn_out, num_Rd_out}), 32'({h.rm, h.rn, h.rd}));
            check_val("used", 32'(used_RmRnRd_out), 32'(h.used));
            check_val("type", 32'(inst_type_out), 32'(h.typ));
            check_val("delayed_B", 32'(delayed_B_out), 32'(h.db));
            check_val("cond", 32'(delayed_cond_out), 32'(h.cond));
            check_val("imm", 32'(imm_out), h.typ[2] ? 32'(h.db[7:0]) : 32'(h.imm));
        end else begin
            check_val("bubble_ctrl", 32'({control_out, used_RmRnRd_out, inst_type_out, delayed_cond_out}), 32'd0);
            check_val("bubble_loads", 32'(loads), 32'd0);
        end
        in_fire  = iv && exp_rdy;
        out_fire = exp_valid && ordy;
        if (r || f) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    ent_t z;
    ent_t a;
    ent_t b;
    ent_t c;
    ent_t d;
    ent_t ld;
    ent_t cons;

    initial begin
        z  = mk(22'h0, 3'd0, 3'd0, 3'b000, 6'h00, 16'h0000, 16'h0000);
        a  = mk(22'h1, 3'd1, 3'd1, 3'b111, 6'h01, 16'h1111, 16'h0101);
        b  = mk(22'h2, 3'd2, 3'd2, 3'b010, 6'h02, 16'h2222, 16'h0202);
        c  = mk(22'h3, 3'd3, 3'd4, 3'b100, 6'h08, 16'h3333, 16'h0303);
        d  = mk(22'h3F_0004, 3'd4, 3'd6, 3'b001, 6'h3F, 16'h4444, 16'h0404);
        ld = mk(22'h100, 3'd0, 3'd3, 3'b100, 6'h00, 16'h0000, 16'h0000);
        cons = mk(22'h5, 3'd3, 3'd1, 3'b001, 6'h00, 16'h5555, 16'h0000);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        control_in = 22'h0; num_Rm_in = 3'd0; num_Rn_in = 3'd0; num_Rd_in = 3'd0;
        imm_in = 16'h0; used_RmRnRd_in = 3'b000; inst_type_in = 6'h00;
        delayed_B_in = 16'h0; delayed_cond_in = 3'd0;
        @(posedge clk);
        #1;
        // Reset held with valid input present
        step(1'b1, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 1'b0, 1'b1, 1'b0, a);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        // Streaming A, B, C
        step(1'b0, 1'b0, 1'b1, 1'b1, a);
        step(1'b0, 1'b0, 1'b1, 1'b1, b);
        step(1'b0, 1'b0, 1'b1, 1'b1, c);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        // Backpressure: fill, hold C, then drain in order
        step(1'b0, 1'b0, 1'b1, 1'b0, a);
        step(1'b0, 1'b0, 1'b1, 1'b0, b);
        step(1'b0, 1'b0, 1'b1, 1'b0, c);
        step(1'b0, 1'b0, 1'b1, 1'b1, c);
        step(1'b0, 1'b0, 1'b1, 1'b1, c);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        // Flush while FULL with D offered
        step(1'b0, 1'b0, 1'b1, 1'b0, a);
        step(1'b0, 1'b0, 1'b1, 1'b0, b);
        step(1'b0, 1'b1, 1'b1, 1'b0, d);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        // Link immediate substitution and plain immediate
        step(1'b0, 1'b0, 1'b1, 1'b1, mk(22'h7, 3'd0, 3'd0, 3'b000, 6'h04, 16'h1234, 16'hABCD));
        step(1'b0, 1'b0, 1'b1, 1'b1, mk(22'h8, 3'd0, 3'd0, 3'b000, 6'h00, 16'h1234, 16'hABCD));
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        // Load-use: consumer waits on the head load when the interlock is built
        step(1'b0, 1'b0, 1'b1, 1'b0, ld);
        step(1'b0, 1'b0, 1'b1, 1'b0, cons);
        step(1'b0, 1'b0, 1'b1, 1'b0, cons);
        step(1'b0, 1'b0, 1'b1, 1'b1, cons);
        step(1'b0, 1'b0, 1'b1, 1'b1, cons);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        // Same head load, consumer with no used registers
        step(1'b0, 1'b0, 1'b1, 1'b0, ld);
        cons.used = 3'b000;
        step(1'b0, 1'b0, 1'b1, 1'b0, cons);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        // Reset mid-FULL loses both entries
        step(1'b0, 1'b0, 1'b1, 1'b0, a);
        step(1'b0, 1'b0, 1'b1, 1'b0, b);
        step(1'b1, 1'b1, 1'b1, 1'b1, c);
        step(1'b0, 1'b0, 1'b0, 1'b1, z);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rand_ent());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_readreg_skid.md
Name: pipeline_readreg_skid

Overview:
Parametrised successor to the fixed read-register pipeline register. It carries the same decode payload: control, register numbers, immediate, used-register mask, instruction type, delayed branch target and delayed condition. It adds a valid/ready handshake, a 2-entry skid buffer so backpressure never drops an instruction, a synchronous flush for branch redirect, and bubble gating of control outputs. It sits between decode and execute.

Parameters:
CTRL_W, 22, control word width
RNUM_W, 3, register-number width
IMM_W, 16, immediate and delayed_B width
TYPE_W, 6, inst_type width
COND_W, 3, delayed_cond width
LOAD_BIT, 8, control bit that marks a load
LINK_TYPE_BIT, 2, inst_type bit that marks BL/BLX
LINK_IMM_W, 8, low delayed_B bits substituted into imm_out for BL/BLX

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all held and incoming entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept
control_in  in  CTRL_W  control word
num_Rm_in / num_Rn_in / num_Rd_in  in  RNUM_W each  register numbers
imm_in  in  IMM_W  immediate
used_RmRnRd_in  in  3  [0]=Rm, [1]=Rn, [2]=Rd
inst_type_in  in  TYPE_W  instruction type
delayed_B_in  in  IMM_W  delayed branch target
delayed_cond_in  in  COND_W  delayed condition
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts
control_out, num_Rm_out, num_Rn_out, num_Rd_out, imm_out, used_RmRnRd_out, inst_type_out, delayed_B_out, delayed_cond_out  out  matching widths  head entry fields
loads  out  1  head entry is a load
hazard_stall  out  1  load-use interlock active

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- Storage: a main register (head) and a skid register, each with a valid bit.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States and transitions:
  - EMPTY: in_fire moves main <= in and goes to ONE.
  - ONE, in_fire & out_fire: main <= in; stay ONE.
  - ONE, in_fire & !out_fire: skid <= in; go to FULL.
  - ONE, out_fire only: go to EMPTY.
  - FULL, out_fire: main <= skid; go to ONE.
  - FULL: incoming data is never captured.
- in_ready:
  - in_ready = (state != FULL) & !flush & !hazard_stall.
  - No combinational path from out_ready to in_ready.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Full throughput of 1 per cycle when out_ready=1. Strict FIFO order.
- out_valid = (state != EMPTY).
- Bubble gating: control_out, used_RmRnRd_out, inst_type_out and delayed_cond_out are forced to 0 when out_valid=0.
- Ungated fields: num_*_out, imm, delayed_B_out are not reset and are don't-care while out_valid=0.
- loads = out_valid & control_out[LOAD_BIT].
- imm_out: when inst_type_out[LINK_TYPE_BIT]=1, imm_out = zero-extended delayed_B_out[LINK_IMM_W-1:0]; otherwise imm_out = stored imm.
- Flush:
  - Next state is EMPTY and both valids clear.
  - The input presented in the flush cycle is dropped.
  - A concurrent out_fire still counts as taken by downstream.
- Reset:
  - Same effect as flush.
  - Reset values: out_valid=0, in_ready=1 the cycle after rst deasserts, control_out=0, used=0, inst_type=0, delayed_cond=0, loads=0, hazard_stall=0.
  - rst has priority over flush and over any in-flight handshake; reset mid-FULL loses both entries.

Optional Feature:
Macro: PIPELINE_READREG_HAZARD_EN.
- Defined:
  - hazard_stall = in_valid & loads & ((used_RmRnRd_in[0] & num_Rm_in==num_Rd_out) | (used_RmRnRd_in[1] & num_Rn_in==num_Rd_out)).
  - Uses the main (head) entry only.
  - When set, in_ready=0, holding the consumer upstream until the load leaves main.
- Not defined: hazard_stall tied to 0 and no comparators are built.

Test Plan:
1. Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, control_out=0, loads=0; the cycle after release, in_ready=1 and nothing was captured.
2. Streaming: out_ready=1, push A, B, C back-to-back (control 22'h1, 22'h2, 22'h3) -> out_valid from cycle+1, outputs A, B, C in consecutive cycles, in_ready constantly 1.
3. Backpressure: out_ready=0, push A, B -> FULL, in_ready=0, head shows A; C held by upstream; raise out_ready -> A, B, C emerge in order with none lost or duplicated.
4. Flush in FULL with in_valid=1 (D) -> next cycle out_valid=0, control_out=0, in_ready=1; D never appears.
5. Link immediate: inst_type bit2=1, delayed_B=16'hABCD, imm=16'h1234 -> imm_out=16'h00CD; with bit2=0 -> imm_out=16'h1234.
6. Hazard (macro on): head is a load (control[8]=1) with Rd=3; input used=3'b001, Rm=3 -> hazard_stall=1, in_ready=0; after the load drains -> accepted. With used=3'b000, or with the macro off -> accepted immediately.
